// File: rtl/fb_stream_writer_pkg.sv
// Shared definitions for the frame-buffer write path: FSM encoding,
// RGB444 field layout, default picture geometry and bank base helpers.
package fb_stream_writer_pkg;

    // Write-side FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_SWAP = 2'd2
    } wr_state_e;

    // RGB444 pixel layout {r, g, b}
    localparam int RGB_R_MSB = 11;
    localparam int RGB_R_LSB = 8;
    localparam int RGB_G_MSB = 7;
    localparam int RGB_G_LSB = 4;
    localparam int RGB_B_MSB = 3;
    localparam int RGB_B_LSB = 0;

    // Default stored-picture geometry
    localparam int DEF_PICTURE_WIDTH  = 320;
    localparam int DEF_PICTURE_HEIGHT = 179;
    localparam int DEF_FRAME_PIX      = DEF_PICTURE_WIDTH * DEF_PICTURE_HEIGHT;

    // Bank bases for the default geometry; the display side uses the same values
    localparam int BANK0_BASE = 0;
    localparam int BANK1_BASE = DEF_FRAME_PIX;

    // Base address of a bank for an arbitrary picture size
    function automatic int unsigned bank_base(input logic bank, input int unsigned frame_pix);
        return bank ? frame_pix : 32'd0;
    endfunction

endpackage

// File: rtl/fb_bank_ctrl.sv
// Double-bank bookkeeping: which bank is written, which is displayed,
// and the display base address. Banks only swap on an explicit request.
module fb_bank_ctrl
    import fb_stream_writer_pkg::*;
#(
    parameter int ADDR_W    = 17,
    parameter int FRAME_PIX = DEF_FRAME_PIX
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              swap,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] rd_base
);

    localparam logic [ADDR_W-1:0] RD_BASE_BANK1 = ADDR_W'(bank_base(1'b1, FRAME_PIX));

    logic wr_bank_reg;
    logic rd_bank_reg;

    // Bank registers: write bank always opposite the displayed bank
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_bank_reg <= 1'b1;
            rd_bank_reg <= 1'b0;
        end else if (swap) begin
            rd_bank_reg <= wr_bank_reg;
            wr_bank_reg <= ~wr_bank_reg;
        end
    end

    assign wr_bank = wr_bank_reg;
    // Base follows the registered read bank, so it changes on the swap edge
    assign rd_base = rd_bank_reg ? RD_BASE_BANK1 : '0;

endmodule

// File: rtl/fb_stream_writer.sv
// Writes one RGB444 picture from a valid/ready stream into the
// non-displayed bank of a double-banked frame buffer, then stalls
// until the display frame boundary to swap banks without tearing.
module fb_stream_writer
    import fb_stream_writer_pkg::*;
#(
    parameter int PICTURE_WIDTH  = DEF_PICTURE_WIDTH,
    parameter int PICTURE_HEIGHT = DEF_PICTURE_HEIGHT,
    parameter int ADDR_W         = 17,
    parameter int DATA_W         = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              frame_tick,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_base,
    output logic              frame_done,
    output logic              resync
);

    localparam int                FRAME_PIX  = PICTURE_WIDTH * PICTURE_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(FRAME_PIX - 1);
    localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(bank_base(1'b1, FRAME_PIX));

    wr_state_e         state_reg, state_next;
    logic [ADDR_W-1:0] pix_idx_reg, pix_idx_next;
    logic [ADDR_W-1:0] wr_idx;
    logic              wr_now;
    logic              done_next;
    logic              resync_next;
    logic              swap;
    logic              wr_bank;
    logic              handshake;

    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              frame_done_reg;
    logic              resync_reg;

    // Stall the source only while a finished picture waits for the swap
    assign s_ready   = ~rst & (state_reg != WAIT_SWAP);
    assign handshake = s_valid & s_ready;

    fb_bank_ctrl #(
        .ADDR_W    (ADDR_W),
        .FRAME_PIX (FRAME_PIX)
    ) u_bank_ctrl (
        .clk     (clk),
        .srst    (rst),
        .swap    (swap),
        .wr_bank (wr_bank),
        .rd_base (rd_base)
    );

    // Next-state, pixel index and write-request decode
    always_comb begin
        state_next   = state_reg;
        pix_idx_next = pix_idx_reg;
        wr_now       = 1'b0;
        wr_idx       = '0;
        done_next    = 1'b0;
        resync_next  = 1'b0;
        swap         = 1'b0;
        case (state_reg)
            IDLE: begin
                // Pixels before the first start-of-frame are discarded
                if (handshake && s_sof) begin
                    wr_now       = 1'b1;
                    pix_idx_next = ADDR_W'(1);
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                if (handshake) begin
                    wr_now = 1'b1;
                    if (s_sof) begin
                        // Source restarted mid-picture: realign to pixel 0
                        pix_idx_next = ADDR_W'(1);
                        resync_next  = 1'b1;
                    end else begin
                        wr_idx = pix_idx_reg;
                        if (pix_idx_reg == LAST_IDX) begin
                            done_next  = 1'b1;
                            state_next = WAIT_SWAP;
                        end else begin
                            pix_idx_next = pix_idx_reg + ADDR_W'(1);
                        end
                    end
                end
            end
            WAIT_SWAP: begin
                if (frame_tick) begin
                    swap         = 1'b1;
                    pix_idx_next = '0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, index and registered RAM port-A write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pix_idx_reg    <= '0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            frame_done_reg <= 1'b0;
            resync_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pix_idx_reg    <= pix_idx_next;
            wr_en_reg      <= wr_now;
            frame_done_reg <= done_next;
            resync_reg     <= resync_next;
            if (wr_now) begin
                wr_addr_reg <= (wr_bank ? BANK1_BASE : '0) + wr_idx;
                wr_data_reg <= s_data;
            end
        end
    end

    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign frame_done = frame_done_reg;
    assign resync     = resync_reg;

endmodule

// File: tb/tb_fb_stream_writer.sv
// Bench for fb_stream_writer on a 4x2 picture: directed scenarios plus
// random traffic, checked every cycle against a picture-level model.
module tb_fb_stream_writer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FP = W * H;
    localparam int AW = 17;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic          frame_tick = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_base;
    logic          frame_done;
    logic          resync;

    int checks = 0;
    int errors = 0;

    fb_stream_writer #(
        .PICTURE_WIDTH  (W),
        .PICTURE_HEIGHT (H),
        .ADDR_W         (AW),
        .DATA_W         (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .frame_tick (frame_tick),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_base    (rd_base),
        .frame_done (frame_done),
        .resync     (resync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Picture-level model: 0 = hunting for start, 1 = filling, 2 = picture complete
    int m_mode  = 0;
    int m_idx   = 0;
    int m_wbank = 1;
    int m_rbase = 0;
    bit e_wr_en = 0;
    bit e_done  = 0;
    bit e_resync = 0;
    int e_addr  = 0;
    int e_data  = 0;

    task automatic put(input int idx);
        e_wr_en = 1;
        e_addr  = m_wbank * FP + idx;
        e_data  = int'(s_data);
    endtask

    always @(posedge clk) begin : model
        bit rdy;
        bit hs;
        rdy = !rst && (m_mode != 2);
        hs  = s_valid && rdy;
        e_wr_en  = 0;
        e_done   = 0;
        e_resync = 0;
        if (rst) begin
            m_mode = 0; m_idx = 0; m_wbank = 1; m_rbase = 0;
            e_addr = 0; e_data = 0;
        end else begin
            case (m_mode)
                0: if (hs && s_sof) begin
                    put(0); m_idx = 1; m_mode = 1;
                end
                1: if (hs) begin
                    if (s_sof) begin
                        put(0); m_idx = 1; e_resync = 1;
                    end else begin
                        put(m_idx);
                        if (m_idx == FP - 1) begin
                            e_done = 1; m_mode = 2;
                        end else begin
                            m_idx++;
                        end
                    end
                end
                default: if (frame_tick) begin
                    m_rbase = m_wbank * FP;
                    m_wbank = 1 - m_wbank;
                    m_idx = 0;
                    m_mode = 0;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("s_ready", int'(s_ready), int'(!rst && (m_mode != 2)));
        chk("wr_en", int'(wr_en), int'(e_wr_en));
        chk("frame_done", int'(frame_done), int'(e_done));
        chk("resync", int'(resync), int'(e_resync));
        chk("rd_base", int'(rd_base), m_rbase);
        if (e_wr_en) begin
            chk("wr_addr", int'(wr_addr), e_addr);
            chk("wr_data", int'(wr_data), e_data);
        end
    end

    task automatic step(input bit v, input bit sof, input int d, input bit tick);
        @(posedge clk);
        #1;
        s_valid    = v;
        s_sof      = sof;
        s_data     = DW'(d);
        frame_tick = tick;
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("lit reset s_ready", int'(s_ready), 0);
        chk("lit reset wr_en", int'(wr_en), 0);
        chk("lit reset rd_base", int'(rd_base), 0);
        rst = 1'b0;

        // First picture into bank 1
        step(1, 1, 'h001, 0);
        for (int d = 2; d <= 8; d++) begin
            step(1, 0, d, 0);
            if (d == 2) begin
                chk("lit first addr", int'(wr_addr), 8);
                chk("lit first data", int'(wr_data), 'h001);
            end
        end
        step(0, 0, 0, 0);
        chk("lit last addr", int'(wr_addr), 15);
        chk("lit last data", int'(wr_data), 'h008);
        chk("lit frame_done", int'(frame_done), 1);
        chk("lit stalled", int'(s_ready), 0);
        step(0, 0, 0, 0);
        chk("lit rd_base before tick", int'(rd_base), 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("lit rd_base after tick", int'(rd_base), 8);
        chk("lit ready after tick", int'(s_ready), 1);

        // Second picture into bank 0
        step(1, 1, 'hA00, 0);
        for (int i = 1; i <= 7; i++) begin
            step(1, 0, 'hA00 + i, 0);
            if (i == 1) chk("lit bank0 first addr", int'(wr_addr), 0);
        end
        step(0, 0, 0, 0);
        chk("lit bank0 last addr", int'(wr_addr), 7);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("lit rd_base back to 0", int'(rd_base), 0);

        // Drops in IDLE, then start; resync at idx 5; tick on the last beat
        for (int k = 0; k < 3; k++) step(1, 0, 'h300 + k, 0);
        step(1, 1, 'h0F0, 0);
        step(0, 0, 0, 0);
        chk("lit sof after drops addr", int'(wr_addr), 8);
        chk("lit sof after drops data", int'(wr_data), 'h0F0);
        for (int k = 1; k <= 4; k++) step(1, 0, 'h310 + k, 0);
        step(1, 1, 'h555, 0);
        for (int k = 1; k <= 7; k++) begin
            step(1, 0, 'h560 + k, (k == 7));
            if (k == 1) begin
                chk("lit resync", int'(resync), 1);
                chk("lit resync addr", int'(wr_addr), 8);
            end
        end
        step(0, 0, 0, 0);
        chk("lit resync frame_done", int'(frame_done), 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("lit coincident tick ignored", int'(rd_base), 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("lit swap after wait", int'(rd_base), 8);

        // Tick during WRITE is ignored
        step(1, 1, 'hB00, 0);
        step(1, 0, 'hB01, 0);
        step(1, 0, 'hB02, 1);
        for (int k = 3; k <= 7; k++) step(1, 0, 'hB00 + k, 0);
        step(0, 0, 0, 0);
        chk("lit tick in write ignored", int'(rd_base), 8);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("lit swap to bank0 display", int'(rd_base), 0);

        // Gapped stream, then reset mid-picture at idx 3
        step(1, 1, 'hC00, 0);
        step(0, 0, 0, 0);
        step(1, 0, 'hC01, 0);
        step(0, 0, 0, 0);
        step(1, 0, 'hC02, 0);
        step(0, 0, 0, 0);
        chk("lit gapped addr", int'(wr_addr), 10);
        rst = 1'b1;
        step(0, 0, 0, 0);
        chk("lit rst wr_en", int'(wr_en), 0);
        chk("lit rst rd_base", int'(rd_base), 0);
        rst = 1'b0;
        step(1, 0, 'hDDD, 0);
        step(0, 0, 0, 0);
        chk("lit no sof after rst", int'(wr_en), 0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            step(($urandom % 10) < 7, ($urandom % 25) == 0,
                 int'($urandom % 4096), ($urandom % 12) == 0);
            rst = (($urandom % 300) == 0);
        end
        rst = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_stream_writer.md
Name: fb_stream_writer

Overview:
- Write-side counterpart of the bouncing-picture display path.
- Accepts a 12-bit RGB444 pixel stream over a valid/ready handshake and writes one full picture into a double-banked frame-buffer RAM (port A).
- Presents the bank to be read (rd_base) to the display side (port B).
- Bank swap happens only at the display frame boundary (h_cnt==0 & v_cnt==0 pulse), so the display never shows a torn picture.

Parameters:
- PICTURE_WIDTH, 320, pixels per line of the stored picture
- PICTURE_HEIGHT, 179, lines per picture
- ADDR_W, 17, frame-buffer address width; 2*W*H must be <= 2^ADDR_W
- DATA_W, 12, pixel width (RGB444)

Ports:
- clk  in  1  pixel clock, shared with the display block
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  source has a pixel
- s_ready  out  1  block accepts a pixel this cycle
- s_data  in  DATA_W  pixel, {r[11:8], g[7:4], b[3:0]}
- s_sof  in  1  qualifies s_data as first pixel of a picture (sampled only on handshake)
- frame_tick  in  1  one-cycle pulse at display frame start (h_cnt==0 & v_cnt==0)
- wr_en  out  1  RAM port-A write strobe
- wr_addr  out  ADDR_W  RAM port-A address
- wr_data  out  DATA_W  RAM port-A data
- rd_base  out  ADDR_W  base address of the bank the display reads; top level adds it to the display's data_addr
- frame_done  out  1  one-cycle pulse when a picture's last pixel is written
- resync  out  1  one-cycle pulse when s_sof arrives mid-picture

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- FRAME_PIX = PICTURE_WIDTH*PICTURE_HEIGHT, 57280 by default.
- Bank 0 base = 0; bank 1 base = FRAME_PIX.
- Handshake occurs when s_valid & s_ready. s_data and s_sof matter only on a handshake.
- Reset values:
  - state=IDLE; pix_idx=0; wr_bank=1; rd_bank=0
  - wr_en=0; wr_addr=0; wr_data=0; rd_base=0
  - frame_done=0; resync=0; s_ready=0 in the reset cycle
- s_ready is 1 in IDLE and WRITE, 0 in WAIT_SWAP. It is combinational from state.
- IDLE:
  - Handshake with s_sof=0: pixel dropped, no write.
  - Handshake with s_sof=1: write at idx 0, pix_idx<=1, go to WRITE.
- WRITE:
  - Each handshake writes at pix_idx, then pix_idx increments.
  - Handshake with s_sof=1: pixel written at idx 0, pix_idx<=1, resync pulses, stay in WRITE.
  - Handshake at pix_idx==FRAME_PIX-1 (s_sof=0): pixel written, frame_done pulses the next cycle, go to WAIT_SWAP.
- WAIT_SWAP:
  - Stream is stalled.
  - On frame_tick: rd_bank<=wr_bank, wr_bank<=~wr_bank, rd_base updated the same edge, pix_idx<=0, go to IDLE.
- frame_tick seen in IDLE or WRITE is ignored, with no swap. A tick on the same cycle as the last-pixel handshake is also ignored; the swap waits for the next tick.
- Write latency is 1 cycle. wr_en, wr_addr = bank_base(wr_bank)+pix_idx and wr_data are registered from the handshake cycle. wr_en=0 when there is no write.
- Address is computed at ADDR_W width; pix_idx is ADDR_W wide and never exceeds FRAME_PIX-1.
- wr_bank != rd_bank at all times, so port A never writes the bank being displayed.
- rst asserted mid-picture: the partial picture is abandoned, all reset values apply, and the next picture needs s_sof.

Decomposition:
- Shared package:
  - state encoding (IDLE, WRITE, WAIT_SWAP)
  - RGB444 field positions
  - default PICTURE_WIDTH/HEIGHT
  - FRAME_PIX and bank base constants, shared with the display block and top level
- Optional sub-module fb_bank_ctrl: holds wr_bank/rd_bank/rd_base and the swap-on-tick logic.
- The FSM, index counter and write register stay in fb_stream_writer.

Test Plan:
- Small config (WIDTH=4, HEIGHT=2, FRAME_PIX=8):
  - Reset, then 8 handshakes, first with s_sof=1, data 0x001..0x008 → writes at addr 8..15 with those data, 1 cycle after each handshake.
  - frame_done pulses once; s_ready drops; rd_base stays 0.
- Following the above, pulse frame_tick → rd_base=8 the next cycle, wr_bank=0, s_ready=1.
  - The next picture (data 0xA00..) writes addr 0..7.
- In IDLE, 3 handshakes with s_sof=0 → no wr_en; pix_idx stays 0.
  - The fourth, with s_sof=1 and data 0x0F0, is written at addr 8.
- s_sof at pix_idx=5 in WRITE → resync pulses; that pixel is written at addr 8; the picture completes after 7 more beats.
- frame_tick during WRITE, and frame_tick coincident with the last handshake → no swap, rd_base unchanged.
  - The swap happens on the next tick while in WAIT_SWAP.
- s_valid toggling 1-0-1 per cycle with 50% gaps → only handshake cycles write; addresses stay contiguous.
  - Then assert rst at pix_idx=3 → wr_en=0 and rd_base=0 the next cycle; state is IDLE.
